// File: rtl/fe_fetch_pkg.sv
// fe_fetch_pkg: shared widths, NOP encoding and fetch FSM states for the fetch stage
// Contents:
//   ADDR_W / INSTR_W   address and instruction widths
//   INSTR_NOP          canonical bubble instruction (addi x0, x0, 0)
//   FE_STATE_W         width of the fetch FSM state
//   fe_state_t         FE_RUN (requesting), FE_HOLD (buffer full), FE_FLUSH (stale request outstanding)
//   word_align()       clears the two byte-offset bits of an address
package fe_fetch_pkg;
    localparam int ADDR_W = 32;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h00000013;
    localparam int FE_STATE_W = 2;
    typedef enum logic [FE_STATE_W-1:0] {
        FE_RUN   = 2'd0,
        FE_HOLD  = 2'd1,
        FE_FLUSH = 2'd2
    } fe_state_t;
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return a & ~(ADDR_W'(3));
    endfunction
endpackage

// File: rtl/fe_hold_buf.sv
// fe_hold_buf: one-entry {pc, instr} holding register for fetches that complete under stall
// Ports:
//   clk, clr        clock, synchronous active-high reset (empties the entry)
//   load            capture in_pc/in_instr and mark full
//   drain           entry consumed, mark empty
//   flush           discard the entry (redirect)
//   in_pc, in_instr entry to capture
//   full            entry holds a fetched instruction
//   pc, instr       stored entry
module fe_hold_buf
    import fe_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               clr,
    input  logic               load,
    input  logic               drain,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               full,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr
);
    always_ff @(posedge clk) begin
        if (clr) begin
            full  <= 1'b0;
            pc    <= '0;
            instr <= INSTR_NOP;
        end else if (flush) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            pc    <= in_pc;
            instr <= in_instr;
        end else if (drain) begin
            full <= 1'b0;
        end
    end
endmodule

// File: rtl/fe_fetch.sv
// fe_fetch: b-risc instruction fetch stage with req/ack imem port, stall buffer and branch redirect
// Parameters:
//   RESET_PC  PC loaded by clr
//   PC_INC    sequential PC increment in bytes
// Ports:
//   clk, clr                      clock, synchronous active-high reset
//   stall                         hold o_pc/o_instr/o_valid
//   i_branch_en, i_branch_target  redirect request and address (bits [1:0] ignored)
//   o_imem_req, o_imem_addr       fetch request and address
//   i_imem_ack, i_imem_data       fetch completion and instruction
//   o_pc, o_instr, o_valid        registered instruction to id (NOP when not valid)
// Optional macro FE_PERF_CNT_EN adds o_fetch_cnt / o_bubble_cnt (unstalled valid / bubble cycles).
module fe_fetch
    import fe_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_INC   = ADDR_W'(4)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               stall,
    input  logic               i_branch_en,
    input  logic [ADDR_W-1:0]  i_branch_target,
    output logic               o_imem_req,
    output logic [ADDR_W-1:0]  o_imem_addr,
    input  logic               i_imem_ack,
    input  logic [INSTR_W-1:0] i_imem_data,
    output logic [ADDR_W-1:0]  o_pc,
    output logic [INSTR_W-1:0] o_instr,
    output logic               o_valid
`ifdef FE_PERF_CNT_EN
    ,
    output logic [31:0]        o_fetch_cnt,
    output logic [31:0]        o_bubble_cnt
`endif
);
    fe_state_t          state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  saved;
    logic [ADDR_W-1:0]  target;
    logic               ack;
    logic               buf_full;
    logic [ADDR_W-1:0]  buf_pc;
    logic [INSTR_W-1:0] buf_instr;
    logic               buf_load;
    logic               buf_drain;
    // Request is gated by clr directly so it is low throughout reset and rises
    // in the very first cycle clr is low.
    assign o_imem_req  = !clr && state != FE_HOLD;
    assign o_imem_addr = pc;
    // Acks arriving with no request outstanding are ignored.
    assign ack         = i_imem_ack && o_imem_req;
    assign target      = word_align(i_branch_target);
    assign buf_load    = !i_branch_en && state == FE_RUN && ack && stall;
    assign buf_drain   = !i_branch_en && state == FE_HOLD && !stall;
    fe_hold_buf u_buf (
        .clk      (clk),
        .clr      (clr),
        .load     (buf_load),
        .drain    (buf_drain),
        .flush    (i_branch_en),
        .in_pc    (pc),
        .in_instr (i_imem_data),
        .full     (buf_full),
        .pc       (buf_pc),
        .instr    (buf_instr)
    );
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= FE_RUN;
            pc      <= RESET_PC;
            saved   <= RESET_PC;
            o_pc    <= RESET_PC;
            o_instr <= INSTR_NOP;
            o_valid <= 1'b0;
        end else if (i_branch_en) begin
            o_instr <= INSTR_NOP;
            o_valid <= 1'b0;
            // A request still in flight must complete before the target can be
            // issued; otherwise redirect immediately.
            if (state == FE_HOLD || ack) begin
                pc    <= target;
                state <= FE_RUN;
            end else begin
                saved <= target;
                state <= FE_FLUSH;
            end
        end else begin
            unique case (state)
                FE_RUN: begin
                    if (ack) begin
                        pc <= pc + PC_INC;
                        if (stall) begin
                            state <= FE_HOLD;
                        end else begin
                            o_pc    <= pc;
                            o_instr <= i_imem_data;
                            o_valid <= 1'b1;
                        end
                    end else if (!stall) begin
                        o_instr <= INSTR_NOP;
                        o_valid <= 1'b0;
                    end
                end
                FE_HOLD: begin
                    if (!stall) begin
                        o_pc    <= buf_pc;
                        o_instr <= buf_instr;
                        o_valid <= buf_full;
                        state   <= FE_RUN;
                    end
                end
                FE_FLUSH: begin
                    if (ack) begin
                        pc    <= saved;
                        state <= FE_RUN;
                    end
                end
                default: state <= FE_RUN;
            endcase
        end
    end
`ifdef FE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            o_fetch_cnt  <= '0;
            o_bubble_cnt <= '0;
        end else if (!stall) begin
            o_fetch_cnt  <= o_fetch_cnt + 32'(o_valid);
            o_bubble_cnt <= o_bubble_cnt + 32'(!o_valid);
        end
    end
`endif
endmodule

// File: doc/fe_fetch.md
# fe_fetch

Instruction fetch stage of the b-risc pipeline. It owns the program counter and issues requests to instruction memory over a req/ack handshake. It presents the registered `o_pc`/`o_instr` pair that the `id` stage consumes on its `i_pc`/`i_instr` inputs. It absorbs downstream stalls with a one-entry buffer and services branch redirects from later stages, inserting NOP bubbles while the redirect takes effect.

## Interface
- `RESET_PC`, default 0: PC loaded by `clr`, `ADDR_W` bits.
- `PC_INC`, default 4: sequential PC increment in bytes.
- `clk`  in  1: pipeline clock; all state updates on the rising edge.
- `clr`  in  1: **one clock; reset is synchronous and active-high.** The clock is `clk` and the reset is `clr`, consistent with the other pipeline stages.
- `stall`  in  1: hold `o_pc`/`o_instr`/`o_valid` this cycle.
- `i_branch_en`  in  1: redirect request from `ex`.
- `i_branch_target`  in  `ADDR_W`: redirect address; bits [1:0] are treated as 0.
- `o_imem_req`  out  1: fetch request.
- `o_imem_addr`  out  `ADDR_W`: fetch address; stable while `o_imem_req` is high and not yet acked.
- `i_imem_ack`  in  1: request completes this cycle; data is valid this cycle.
- `i_imem_data`  in  `INSTR_W`: fetched instruction.
- `o_pc`  out  `ADDR_W`: PC of `o_instr`.
- `o_instr`  out  `INSTR_W`: instruction to `id`; NOP (`INSTR_NOP` = 32'h00000013) when `o_valid` is 0.
- `o_valid`  out  1: `o_instr` is a real fetched instruction.

## Operation
- Registers: `pc` (next fetch address), FSM state, buffer {`pc`, `instr`}, saved target, output registers.
- States:
  - RUN: `o_imem_req`=1, `o_imem_addr`=`pc`.
  - HOLD: buffer full, `o_imem_req`=0.
  - FLUSH: request outstanding, its data will be discarded.
- Priority each cycle: `clr` > `i_branch_en` > `stall`.
- RUN:
  - Ack and no stall: outputs <= {`pc`, data, valid=1}; `pc` += `PC_INC`.
  - Ack and stall: buffer <= {`pc`, data}; `pc` += `PC_INC`; go to HOLD.
  - No ack and no stall: outputs <= NOP, valid=0 (bubble).
- HOLD:
  - No stall: outputs <= buffer, valid=1; go to RUN. The request is reissued in the following cycle.
  - Stall: outputs and buffer hold.
- Branch, any state:
  - Outputs <= NOP, valid=0, regardless of `stall`.
  - The buffer is discarded.
  - RUN with no ack this cycle: save the target, go to FLUSH.
  - RUN with ack this cycle, or HOLD: discard the data, `pc` <= target, go to RUN.
- FLUSH:
  - `o_imem_req` stays high at the old address until ack.
  - On ack: discard the data, `pc` <= saved target, go to RUN.
  - A further branch while in FLUSH overwrites the saved target.
- `i_imem_ack` while `o_imem_req`=0 is ignored.
- PC arithmetic wraps modulo 2^`ADDR_W`.

## Timing
- Reset values:
  - `o_pc`=`RESET_PC`, `o_instr`=NOP, `o_valid`=0.
  - `o_imem_req`=0, `o_imem_addr`=`RESET_PC`.
  - State=RUN, buffer empty.
- `o_imem_req` rises in the first cycle after `clr` falls.
- Latency: an ack in cycle n puts the instruction on `o_instr` at cycle n+1 when not stalled.
- With zero-wait memory (ack in the same cycle as req) throughput is 1 instruction per cycle.
- Branch in cycle n with no request outstanding:
  - Bubble at n+1.
  - Request to the target at n+1.
  - Target instruction at n+2 at the earliest.
- `clr` mid-transaction abandons the outstanding request; the memory must tolerate req dropping without ack.
- Stall for k cycles loses no instruction and duplicates none.

## Configuration
- `FE_PERF_CNT_EN`, when defined, adds two outputs:
  - `o_fetch_cnt[31:0]`: count of cycles with `o_valid`=1 and no stall.
  - `o_bubble_cnt[31:0]`: count of cycles with `o_valid`=0 and no stall.
- Both counters clear on `clr` and wrap at 2^32.
- When the macro is undefined, neither the ports nor the logic exist.

## Structure
- `INSTR_NOP`, the FSM state encodings and `FE_STATE_W` go in the shared headers alongside `ADDR_W`/`INSTR_W` (config/opcodes headers).
- Sub-module `fe_hold_buf`: the one-entry {`pc`, `instr`} holding register with load, drain and flush.

## Test plan
- Zero-wait memory (ack tied to req), no stall, `RESET_PC`=0 -> `o_pc` = 0, 4, 8, 12 on consecutive cycles starting the 2nd cycle after `clr` falls; `o_valid`=1 throughout.
- Ack delayed 2 cycles per request -> `o_imem_addr` is stable during each wait; exactly 2 NOP bubbles between instructions; no duplicated PC.
- Stall held 3 cycles while an ack arrives at PC 8 -> outputs hold PC 4; `o_imem_req` drops; after release PC 8 then PC 12 appear once each.
- Branch to 0x100 while a request to 0x10 is outstanding, ack 2 cycles later -> data for 0x10 never appears; next request address is 0x100; `o_valid`=0 until 0x100 issues.
- Branch coincident with stall in HOLD -> buffer dropped; NOP output; next fetch at the target.
- `clr` asserted mid-wait -> the next cycle shows `o_imem_req`=0 and all outputs at their reset values; with `FE_PERF_CNT_EN` defined, both counters read 0.
